// File: rtl/xcorr_peak_detect.sv
// xcorr_peak_detect: tracks the lag of the maximum cross-correlation value
// within a frame and reports it as a signed TDOA over a valid/ready handshake.
// Optional build macro XCORR_PEAK_ABS_EN: compare |xc_result| (saturating)
// instead of the signed value; peak_value still reports the signed sample.
module xcorr_peak_detect #(
    parameter int unsigned DATAWIDTH       = 24,
    parameter int unsigned SEQUENCE_LENGTH = 512,
    parameter int unsigned LAG_W           = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   xc_valid,
    input  logic [2*DATAWIDTH-1:0] xc_result,
    input  logic [LAG_W-1:0]       xc_lag,
    input  logic                   xc_last,
    output logic                   busy,
    output logic                   peak_valid,
    input  logic                   peak_ready,
    output logic [LAG_W:0]         peak_tdoa,
    output logic [2*DATAWIDTH-1:0] peak_value,
    output logic                   peak_err
);

    localparam int unsigned CW        = 2 * DATAWIDTH;
    localparam int unsigned TW        = LAG_W + 1;
    localparam int unsigned CNT_W     = LAG_W + 1;
    localparam int unsigned FRAME_LEN = 2 * SEQUENCE_LENGTH - 1;

    localparam logic [CW-1:0]    MOST_NEG  = {1'b1, {(CW-1){1'b0}}};
`ifdef XCORR_PEAK_ABS_EN
    localparam logic [CW-1:0]    MOST_POS  = {1'b0, {(CW-1){1'b1}}};
`endif
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [TW-1:0]    ZERO_LAG  = TW'(SEQUENCE_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic signed [CW-1:0]  max_key;
    logic [CW-1:0]         best_val;
    logic [LAG_W-1:0]      best_lag;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf;

    logic signed [CW-1:0]  key_c;
    logic                  take_c;
    logic [CNT_W-1:0]      cnt_inc_c;
    logic signed [CW-1:0]  fold_key_c;
    logic [CW-1:0]         fold_val_c;
    logic [LAG_W-1:0]      fold_lag_c;

    // Comparison key, saturating counter increment and the max/lag fold of the current sample
    always_comb begin
`ifdef XCORR_PEAK_ABS_EN
        if (xc_result[CW-1]) begin
            key_c = (xc_result == MOST_NEG) ? MOST_POS : -xc_result;
        end else begin
            key_c = xc_result;
        end
`else
        key_c = xc_result;
`endif
        take_c     = key_c > max_key;
        cnt_inc_c  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        fold_key_c = take_c ? key_c     : max_key;
        fold_val_c = take_c ? xc_result : best_val;
        fold_lag_c = take_c ? xc_lag    : best_lag;
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            peak_valid <= 1'b0;
            peak_tdoa  <= '0;
            peak_value <= '0;
            peak_err   <= 1'b0;
            max_key    <= MOST_NEG;
            best_val   <= '0;
            best_lag   <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= TRACK;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        max_key  <= MOST_NEG;
                        best_val <= '0;
                        best_lag <= '0;
                        ovf      <= 1'b0;
                    end
                end
                TRACK: begin
                    if (start) begin
                        // restart discards the partial frame, including a same-cycle sample
                        cnt      <= '0;
                        max_key  <= MOST_NEG;
                        best_val <= '0;
                        best_lag <= '0;
                        ovf      <= 1'b0;
                    end else if (xc_valid) begin
                        cnt      <= cnt_inc_c;
                        max_key  <= fold_key_c;
                        best_val <= fold_val_c;
                        best_lag <= fold_lag_c;
                        if (cnt_inc_c == FRAME_CNT && !xc_last) begin
                            ovf <= 1'b1;
                        end
                        if (xc_last) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            peak_valid <= 1'b1;
                            peak_tdoa  <= TW'(fold_lag_c) - ZERO_LAG;
                            peak_value <= fold_val_c;
                            peak_err   <= ovf || (cnt_inc_c != FRAME_CNT);
                        end
                    end
                end
                DONE: begin
                    if (peak_ready) begin
                        state      <= IDLE;
                        peak_valid <= 1'b0;
                        peak_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Directed bench for xcorr_peak_detect (N=8) with a scoreboard of expected peaks.
module tb_xcorr_peak_detect;

    localparam int unsigned DW = 24;
    localparam int unsigned N  = 8;
    localparam int unsigned LW = 5;
    localparam int unsigned CW = 2 * DW;
    localparam int unsigned TW = LW + 1;
    localparam int unsigned FL = 2 * N - 1;

    localparam logic [CW-1:0] MOST_NEG = {1'b1, {(CW-1){1'b0}}};
`ifdef XCORR_PEAK_ABS_EN
    localparam logic [CW-1:0] MOST_POS = {1'b0, {(CW-1){1'b1}}};
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic          xc_valid;
    logic [CW-1:0] xc_result;
    logic [LW-1:0] xc_lag;
    logic          xc_last;
    logic          busy;
    logic          peak_valid;
    logic          peak_ready;
    logic [TW-1:0] peak_tdoa;
    logic [CW-1:0] peak_value;
    logic          peak_err;

    xcorr_peak_detect #(
        .DATAWIDTH      (DW),
        .SEQUENCE_LENGTH(N),
        .LAG_W          (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .xc_valid  (xc_valid),
        .xc_result (xc_result),
        .xc_lag    (xc_lag),
        .xc_last   (xc_last),
        .busy      (busy),
        .peak_valid(peak_valid),
        .peak_ready(peak_ready),
        .peak_tdoa (peak_tdoa),
        .peak_value(peak_value),
        .peak_err  (peak_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] tdoa;
        logic [CW-1:0] value;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    exp_t          last_exp;
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] vals[0:31];
    logic [LW-1:0] lags[0:31];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic signed [CW-1:0] key_of(input logic [CW-1:0] v);
`ifdef XCORR_PEAK_ABS_EN
        if (v[CW-1]) return (v == MOST_NEG) ? MOST_POS : -v;
        return v;
`else
        return v;
`endif
    endfunction

    // Reference peak search over vals/lags[0..n-1], pushed to the scoreboard
    task automatic model_push(input int n);
        logic signed [CW-1:0] bk;
        logic [CW-1:0]        bv;
        logic [LW-1:0]        bl;
        exp_t                 e;
        bk = MOST_NEG;
        bv = '0;
        bl = '0;
        for (int i = 0; i < n; i++) begin
            if (key_of(vals[i]) > bk) begin
                bk = key_of(vals[i]);
                bv = vals[i];
                bl = lags[i];
            end
        end
        e.tdoa  = TW'(bl) - TW'(N - 1);
        e.value = bv;
        e.err   = (n != FL);
        sb.push_back(e);
    endtask

    // Start a frame (optionally via a mid-frame restart) and stream n samples
    task automatic run_frame(input int n, input bit restart);
        model_push(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        if (restart) begin
            for (int j = 0; j < 5; j++) begin
                xc_valid  = 1'b1;
                xc_result = CW'(1000000 + j);
                xc_lag    = LW'(j);
                tick();
            end
            start     = 1'b1;
            xc_result = CW'(2000000);
            xc_lag    = LW'(9);
            tick();
            start    = 1'b0;
            xc_valid = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            xc_valid  = 1'b1;
            xc_result = vals[i];
            xc_lag    = lags[i];
            xc_last   = (i == n - 1);
            if (i == n - 1) chk("no_early_valid", 64'(peak_valid), 64'd0);
            tick();
        end
        xc_valid = 1'b0;
        xc_last  = 1'b0;
        chk("latency_1cyc", 64'(peak_valid), 64'd1);
    endtask

    // Wait (bounded) for a result and compare it with the scoreboard head
    task automatic check_peak();
        int k;
        k = 0;
        while (!peak_valid && k < 50) begin
            tick();
            k++;
        end
        chk("peak_timeout", 64'(peak_valid), 64'd1);
        chk("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            last_exp = sb.pop_front();
            chk("peak_tdoa", 64'(peak_tdoa), 64'(last_exp.tdoa));
            chk("peak_value", 64'(peak_value), 64'(last_exp.value));
            chk("peak_err", 64'(peak_err), 64'(last_exp.err));
        end
        chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic handshake();
        peak_ready = 1'b1;
        tick();
        peak_ready = 1'b0;
        chk("valid_drop", 64'(peak_valid), 64'd0);
        chk("err_clear", 64'(peak_err), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_valid"}, 64'(peak_valid), 64'd0);
        chk({tag, "_tdoa"}, 64'(peak_tdoa), 64'd0);
        chk({tag, "_value"}, 64'(peak_value), 64'd0);
        chk({tag, "_err"}, 64'(peak_err), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        xc_valid   = 1'b0;
        xc_result  = '0;
        xc_lag     = '0;
        xc_last    = 1'b0;
        peak_ready = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // ramp 0..14 on lags 0..14
        for (int i = 0; i < 15; i++) begin
            vals[i] = CW'(i);
            lags[i] = LW'(i);
        end
        run_frame(15, 1'b0);
        check_peak();
        chk("ramp_tdoa_p7", 64'(peak_tdoa), 64'd7);
        chk("ramp_value_14", 64'(peak_value), 64'd14);
        handshake();

        // all -5, lag 3 = -1
        for (int i = 0; i < 15; i++) vals[i] = CW'(-5);
        vals[3] = CW'(-1);
        run_frame(15, 1'b0);
        check_peak();
        chk("neg_tdoa_m4", 64'(peak_tdoa), 64'h3C);
        handshake();

        // ties at lags 2 and 9
        for (int i = 0; i < 15; i++) vals[i] = CW'(-5);
        vals[2] = CW'(7);
        vals[9] = CW'(7);
        run_frame(15, 1'b0);
        check_peak();
        chk("tie_tdoa_m5", 64'(peak_tdoa), 64'h3B);
        handshake();

        // short frame of 10 samples
        run_frame(10, 1'b0);
        check_peak();
        chk("short_err", 64'(peak_err), 64'd1);
        handshake();

        // random full frame, then hold ready low with a stray start
        for (int i = 0; i < 15; i++) vals[i] = CW'({$urandom(), $urandom()});
        for (int i = 0; i < 15; i++) lags[i] = LW'(i);
        run_frame(15, 1'b0);
        check_peak();
        for (int c = 0; c < 20; c++) begin
            start = (c == 7);
            tick();
            chk("hold_valid", 64'(peak_valid), 64'd1);
            chk("hold_tdoa", 64'(peak_tdoa), 64'(last_exp.tdoa));
            chk("hold_value", 64'(peak_value), 64'(last_exp.value));
        end
        start = 1'b0;
        handshake();
        tick();
        chk("start_in_done_ignored", 64'(busy), 64'd0);

        // reset at sample 6 of a frame
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xc_valid  = 1'b1;
            xc_result = CW'(50 + i);
            xc_lag    = LW'(i);
            tick();
        end
        rst       = 1'b1;
        xc_result = CW'(500);
        xc_last   = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        tick();
        xc_valid = 1'b0;
        xc_last  = 1'b0;
        tick();
        chk("midrst_no_peak", 64'(peak_valid), 64'd0);
        chk("idle_valid_ignored", 64'(busy), 64'd0);

        // restart mid-frame: only post-restart samples count
        for (int i = 0; i < 15; i++) vals[i] = CW'(100 - ((i * 7) % 15) * 3);
        run_frame(15, 1'b1);
        check_peak();
        handshake();

        // lag 5 = -100, others within +/-50
        for (int i = 0; i < 15; i++) vals[i] = CW'(((i * 37) % 101) - 50);
        vals[5] = CW'(-100);
        run_frame(15, 1'b0);
        check_peak();
`ifdef XCORR_PEAK_ABS_EN
        chk("abs_tdoa_m2", 64'(peak_tdoa), 64'h3E);
        chk("abs_value", 64'(peak_value), 64'(CW'(-100)));
`else
        chk("signed_value_pos", 64'(peak_value[CW-1]), 64'd0);
`endif
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xcorr_peak_detect.md
Name: xcorr_peak_detect

Overview:
- Consumer of the cross-correlation stream from the XCORR engine: takes one (result, lag) pair per valid cycle for a microphone pair and finds the lag with the maximum correlation.
- Reports that lag as a signed TDOA in samples, for the beam-steering and localisation logic of the acoustic camera.
- Sits between the XCORR DSP block and the TDOA/angle solver.
- Uses a valid/ready output handshake and holds its result until the solver takes it.

Parameters:
- DATAWIDTH, 24, sample width; correlation value is 2*DATAWIDTH bits, signed.
- SEQUENCE_LENGTH, 512, samples per sequence N; a frame carries 2N-1 lags.
- LAG_W, 12, lag index width; must satisfy 2^LAG_W >= 2N-1.

Ports:
- clk, input, 1: single system clock.
- rst, input, 1: reset, synchronous, active-high.
- start, input, 1: one-cycle pulse that arms a new frame.
- xc_valid, input, 1: correlation sample valid.
- xc_result, input, 2*DATAWIDTH: signed correlation value.
- xc_lag, input, LAG_W: unsigned lag index, 0..2N-2; index N-1 means zero delay.
- xc_last, input, 1: marks the final sample of the frame; qualified by xc_valid.
- busy, output, 1: high from the cycle after start until peak_valid is asserted.
- peak_valid, output, 1: result available.
- peak_ready, input, 1: downstream accept.
- peak_tdoa, output, LAG_W+1: signed value, xc_lag(best) - (N-1).
- peak_value, output, 2*DATAWIDTH: best correlation value.
- peak_err, output, 1: frame sample count was not equal to 2N-1.

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset: state IDLE, all outputs 0, internal max = most-negative value, sample counter = 0.
- FSM IDLE: on start go to TRACK; clear the counter; load max with the most-negative value; clear the best lag to 0. xc_valid in IDLE is ignored.
- FSM TRACK, each xc_valid cycle:
  - counter increments.
  - If xc_result > max (signed compare, strictly greater), max <= xc_result and best lag <= xc_lag.
  - Ties keep the earlier (lower-index) lag.
- TRACK exit: on xc_valid && xc_last, fold in the last sample the same way and go to DONE next cycle.
- TRACK overflow: if the counter reaches 2N-1 without xc_last, set an overflow flag. Later samples are still compared. The frame still ends only on xc_last.
- DONE:
  - peak_valid = 1; peak_tdoa = best lag - (N-1), sign-extended to LAG_W+1 bits.
  - peak_value = max.
  - peak_err = (final count != 2N-1).
  - Outputs stay stable while peak_valid && !peak_ready.
  - On peak_valid && peak_ready: return to IDLE, deassert peak_valid on the next edge, clear peak_err.
- Latency: peak_valid rises exactly 1 cycle after the xc_last beat.
- start in TRACK: restart the frame (discard the partial max). start in DONE: ignored until the handshake completes.
- start with xc_valid in the same cycle: start wins; that sample is not counted.
- rst mid-frame: abort immediately to the reset state; no partial result is emitted.
- xc_lag outside 0..2N-2: accepted as given, no range check.

Optional Feature:
- Macro XCORR_PEAK_ABS_EN.
- Defined: compare |xc_result| instead of the signed value.
  - Magnitude saturates: the most-negative input maps to the most-positive value.
  - peak_value reports the original signed value of the winning sample.
  - Used for phase-inverted microphone pairs.
- Undefined: signed comparison only; no abs logic is synthesised.

Test Plan:
- N=8, start, then 15 samples with lag 0..14, values ramp 0..14, last on lag 14 -> peak_tdoa=+7, peak_value=14, peak_err=0, peak_valid exactly 1 cycle after last.
- N=8, all values -5 except lag 3 = -1 -> peak_tdoa=-4, peak_value=-1; ties at lags 2 and 9 with equal max -> lag 2 reported.
- Frame ends with xc_last after 10 samples (N=8) -> peak_err=1; a second frame after the handshake with 15 samples -> peak_err=0.
- Hold peak_ready low 20 cycles -> peak_valid, peak_tdoa and peak_value stable; a start pulse during the hold is ignored; ready=1 -> IDLE next cycle.
- rst asserted at sample 6 of a frame -> all outputs 0 next cycle, no peak_valid. start mid-frame -> only post-restart samples count.
- With XCORR_PEAK_ABS_EN: lag 5 = -100, others within ±50 -> peak_tdoa=-2 (N=8), peak_value=-100; without the macro -> the maximum positive sample wins.
